// File: rtl/wsn_radio_tx_if.sv
// wsn_radio_tx_if
// Byte handshake between the CPU side and the radio transmitter.
//   tx_data  : payload byte
//   tx_valid : tx_data/tx_last are valid this cycle
//   tx_last  : the current byte is the final payload byte of the frame
//   tx_ready : the transmitter can accept a byte this cycle
// A byte transfers on a cycle where tx_valid and tx_ready are both high.
interface wsn_radio_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/wsn_radio_tx.sv
// wsn_radio_tx
// OOK frame transmitter for a shared antenna wire. A frame is two 0xAA
// preamble bytes, one 0x2D sync byte, the payload bytes, then a CRC-8
// (poly 0x07, init 0x00) over the payload. Each bit is held DIV cycles,
// MSB first. Frames are followed by GAP bit-times of silence.
// Ports:
//   clk       : system clock, all logic on posedge
//   reset     : synchronous, active-high
//   tx        : byte handshake (slave side of wsn_radio_tx_if)
//   antena    : serial bit stream, 0 whenever not on air
//   antena_oe : drive enable, high only while a frame is on air
//   busy      : high in any state other than IDLE
//   done      : one-cycle pulse in the first GAP cycle after a complete frame
//   underrun  : one-cycle pulse in the first GAP cycle after an aborted frame
module wsn_radio_tx #(
  parameter int DIV = 16,
  parameter int GAP = 4
) (
  input  logic           clk,
  input  logic           reset,
  wsn_radio_tx_if.slave  tx,
  output logic           antena,
  output logic           antena_oe,
  output logic           busy,
  output logic           done,
  output logic           underrun
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SYNC, S_PAY, S_CRC, S_GAP} state_t;

  localparam logic [7:0]  DIV_LAST = 8'(DIV - 1);
  localparam logic [11:0] GAP_LAST = 12'(GAP * DIV - 1);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_div_cnt;
  logic [2:0]  r_bit_idx;
  logic        r_pre_second;
  logic [11:0] r_gap_cnt;
  logic [7:0]  r_hold, r_shift, r_crc;
  logic        r_full, r_hold_last, r_cur_last, r_last_seen;
  logic        r_done, r_underrun;

  logic w_accept, w_on_air, w_bit_end, w_byte_end, w_gap_end;
  logic w_load_pay, w_done_set, w_under_set;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] d);
    logic [7:0] c;
    c = crc_in ^ d;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

  assign w_on_air   = (r_state == S_PRE) || (r_state == S_SYNC) ||
                      (r_state == S_PAY) || (r_state == S_CRC);
  assign w_bit_end  = w_on_air && (r_div_cnt == DIV_LAST);
  assign w_byte_end = w_bit_end && (r_bit_idx == 3'd7);
  assign w_gap_end  = (r_state == S_GAP) && (r_gap_cnt == GAP_LAST);

  // Ready is gated by the reset input so nothing is accepted while reset is held.
  assign tx.tx_ready = !reset && !r_full && !r_last_seen &&
                       ((r_state == S_IDLE) || (r_state == S_PRE) ||
                        (r_state == S_SYNC) || (r_state == S_PAY));
  assign w_accept    = tx.tx_valid && tx.tx_ready;

  assign antena    = w_on_air & r_shift[7];
  assign antena_oe = w_on_air;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign underrun  = r_underrun;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_pay  = 1'b0;
    w_done_set  = 1'b0;
    w_under_set = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_PRE;
      S_PRE:  if (w_byte_end && r_pre_second) w_state_nxt = S_SYNC;
      S_SYNC: if (w_byte_end) begin
        w_state_nxt = S_PAY;
        w_load_pay  = 1'b1;
      end
      S_PAY: if (w_byte_end) begin
        if (r_cur_last)  w_state_nxt = S_CRC;
        else if (r_full) w_load_pay  = 1'b1;
        else begin
          // Starved at a byte boundary: abandon the frame.
          w_state_nxt = S_GAP;
          w_under_set = 1'b1;
        end
      end
      S_CRC: if (w_byte_end) begin
        w_state_nxt = S_GAP;
        w_done_set  = 1'b1;
      end
      S_GAP:  if (w_gap_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control state: flags, counters, CRC accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_full       <= 1'b0;
      r_last_seen  <= 1'b0;
      r_cur_last   <= 1'b0;
      r_crc        <= 8'h00;
      r_div_cnt    <= 8'd0;
      r_bit_idx    <= 3'd0;
      r_pre_second <= 1'b0;
      r_gap_cnt    <= 12'd0;
      r_done       <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_done     <= w_done_set;
      r_underrun <= w_under_set;

      // A byte accepted on the abort edge belongs to a dead frame and is dropped.
      if (w_under_set)     r_full <= 1'b0;
      else if (w_accept)   r_full <= 1'b1;
      else if (w_load_pay) r_full <= 1'b0;

      if (w_under_set || w_gap_end)   r_last_seen <= 1'b0;
      else if (w_accept && tx.tx_last) r_last_seen <= 1'b1;

      if (w_load_pay) begin
        r_crc      <= crc8_byte(r_crc, r_hold);
        r_cur_last <= r_hold_last;
      end else if ((r_state == S_IDLE) && w_accept) begin
        r_crc <= 8'h00;
      end

      if (w_on_air) begin
        r_div_cnt <= w_bit_end ? 8'd0 : r_div_cnt + 8'd1;
        if (w_bit_end) r_bit_idx <= r_bit_idx + 3'd1;
      end else begin
        r_div_cnt <= 8'd0;
        r_bit_idx <= 3'd0;
      end

      // Toggles once per preamble byte; returns to 0 as PRE is left.
      if ((r_state == S_PRE) && w_byte_end) r_pre_second <= ~r_pre_second;

      r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + 12'd1 : 12'd0;
    end
  end

  // Data path: holding register and output shifter.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_hold      <= tx.tx_data;
      r_hold_last <= tx.tx_last;
    end
    // Preloaded while idle so the first preamble bit is on air in the first PRE cycle.
    if (r_state == S_IDLE) begin
      r_shift <= 8'hAA;
    end else if (w_byte_end) begin
      case (r_state)
        S_PRE:   r_shift <= r_pre_second ? 8'h2D : 8'hAA;
        S_SYNC:  r_shift <= r_hold;
        S_PAY:   r_shift <= r_cur_last ? r_crc : r_hold;
        default: r_shift <= r_shift;
      endcase
    end else if (w_bit_end) begin
      r_shift <= {r_shift[6:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_wsn_radio_tx.sv
module tb_wsn_radio_tx;
  localparam int DIV      = 16;
  localparam int GAP      = 4;
  localparam int BYTE_CYC = 8 * DIV;

  logic clk = 1'b0;
  logic reset;
  logic antena, antena_oe, busy, done, underrun;

  wsn_radio_tx_if ifc();

  wsn_radio_tx #(.DIV(DIV), .GAP(GAP)) dut (
    .clk       (clk),
    .reset     (reset),
    .tx        (ifc.slave),
    .antena    (antena),
    .antena_oe (antena_oe),
    .busy      (busy),
    .done      (done),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  int nchecks = 0;
  int nerrors = 0;

  task automatic chk(input string name, input int act, input int expv);
    nchecks++;
    if (act !== expv) begin
      nerrors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, expv, expv);
    end
  endtask

  // Bit-serial CRC-8 (poly 0x07, init 0, no reflection, no final XOR).
  function automatic logic [7:0] crc8_of(input logic [7:0] arr[$]);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    foreach (arr[i]) begin
      for (int k = 7; k >= 0; k--) begin
        fb = c[7] ^ arr[i][k];
        c  = {c[6:0], 1'b0};
        if (fb) c = c ^ 8'h07;
      end
    end
    return c;
  endfunction

  // Frame-level model: phase 0 idle, 1 on air, 2 gap; m_p counts cycles since
  // the first on-air cycle; m_pay holds the payload bytes accepted this frame.
  int         m_phase = 0;
  int         m_p     = 0;
  int         m_L     = 0;
  bit         m_last  = 1'b0;
  bit         m_done  = 1'b0;
  bit         m_under = 1'b0;
  bit         m_armed = 1'b0;
  logic [7:0] m_pay[$];

  function automatic bit model_ready();
    int b;
    int loaded;
    if (reset || !m_armed) return 1'b0;
    if (m_phase == 0) return 1'b1;
    if (m_phase == 2) return 1'b0;
    if (m_last) return 1'b0;
    b      = m_p / BYTE_CYC;
    loaded = (b >= 3) ? b - 2 : 0;
    return (m_pay.size() <= loaded);
  endfunction

  function automatic logic exp_antena();
    int         b;
    int         bitpos;
    logic [7:0] v;
    if (m_phase != 1) return 1'b0;
    b      = m_p / BYTE_CYC;
    bitpos = 7 - (m_p % BYTE_CYC) / DIV;
    if (b < 2)                    v = 8'hAA;
    else if (b == 2)              v = 8'h2D;
    else if (b - 3 < m_pay.size()) v = m_pay[b - 3];
    else                          v = crc8_of(m_pay);
    return v[bitpos];
  endfunction

  always @(posedge clk) begin
    bit acc;
    int b;
    acc     = ifc.tx_valid && model_ready();
    m_done  = 1'b0;
    m_under = 1'b0;
    if (reset) begin
      m_armed = 1'b1;
      m_phase = 0;
      m_p     = 0;
      m_last  = 1'b0;
      m_pay.delete();
    end else begin
      case (m_phase)
        0: if (acc) begin
          m_phase = 1;
          m_p     = 0;
          m_pay.delete();
          m_pay.push_back(ifc.tx_data);
          m_last  = ifc.tx_last;
        end
        1: begin
          m_p++;
          if (m_p % BYTE_CYC == 0) begin
            b = m_p / BYTE_CYC;
            if (m_last && b == 4 + m_pay.size()) begin
              m_L = m_p; m_phase = 2; m_done = 1'b1;
            end else if (!m_last && b >= 4 && (b - 3) >= m_pay.size()) begin
              m_L = m_p; m_phase = 2; m_under = 1'b1;
            end
          end
          if (m_phase == 1 && acc) begin
            m_pay.push_back(ifc.tx_data);
            if (ifc.tx_last) m_last = 1'b1;
          end
        end
        default: begin
          m_p++;
          if (m_p == m_L + GAP * DIV) begin
            m_phase = 0;
            m_last  = 1'b0;
          end
        end
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [5:0] expv;
    logic [5:0] actv;
    if (m_armed) begin
      expv = {exp_antena(), (m_phase == 1), (m_phase != 0), m_done, m_under, model_ready()};
      actv = {antena, antena_oe, busy, done, underrun, ifc.tx_ready};
      nchecks++;
      if (actv !== expv) begin
        nerrors++;
        $display("FAIL cycle_cmp t=%0t: ant/oe/busy/done/under/rdy got %b expected %b",
                 $time, actv, expv);
      end
    end
  end

  // Observation of the air interface: captured bytes (mid-bit sampling),
  // on-air length, pulse counts and timestamps.
  logic       prev_oe   = 1'b0;
  int         cyc       = 0;
  int         cap_t     = 0;
  int         oe_len    = 0;
  int         done_cnt  = 0;
  int         under_cnt = 0;
  int         done_cyc  = 0;
  int         rise_cyc  = 0;
  logic [7:0] cap_sh    = 8'h00;
  logic [7:0] cap_q[$];

  always @(negedge clk) begin
    cyc++;
    if (antena_oe) begin
      if (!prev_oe) begin
        cap_q.delete();
        cap_t    = 0;
        rise_cyc = cyc;
      end
      if (cap_t % DIV == DIV / 2) begin
        cap_sh = {cap_sh[6:0], antena};
        if ((cap_t / DIV) % 8 == 7) cap_q.push_back(cap_sh);
      end
      cap_t++;
      oe_len = cap_t;
    end
    prev_oe = antena_oe;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (underrun) under_cnt++;
  end

  logic [7:0] exp_q[$];

  task automatic check_bytes(input string name);
    chk({name, "_len"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < cap_q.size()) chk($sformatf("%s_byte%0d", name, i), cap_q[i], exp_q[i]);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push_byte(input logic [7:0] d, input logic l, input bit keep_valid);
    int w;
    w = 0;
    ifc.tx_valid = 1'b1;
    ifc.tx_data  = d;
    ifc.tx_last  = l;
    while (1) begin
      @(negedge clk);
      if (ifc.tx_ready) break;
      w++;
      if (w > 5000) begin
        nchecks++; nerrors++;
        $display("FAIL push_ready: tx_ready stayed %0d for %0d cycles, required 1", ifc.tx_ready, w);
        break;
      end
    end
    @(posedge clk); #1;
    if (!keep_valid) ifc.tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (1) begin
      @(negedge clk);
      if (!busy) break;
      w++;
      if (w > 5000) begin
        nchecks++; nerrors++;
        $display("FAIL wait_idle: busy still %0d after %0d cycles, required 0", busy, w);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int d1;
    int r2;
    reset        = 1'b1;
    ifc.tx_valid = 1'b0;
    ifc.tx_data  = 8'h00;
    ifc.tx_last  = 1'b0;

    exp_q = {8'h01};
    chk("model_crc_01", crc8_of(exp_q), 8'h07);
    exp_q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("model_crc_123456789", crc8_of(exp_q), 8'hF4);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", ifc.tx_ready, 1);
    chk("busy_after_reset", busy, 0);
    @(posedge clk); #1;

    // Single byte frame.
    push_byte(8'h01, 1'b1, 1'b0);
    wait_idle();
    chk("A_oe_len", oe_len, 640);
    chk("A_done_cnt", done_cnt, 1);
    exp_q = {8'hAA, 8'hAA, 8'h2D, 8'h01, 8'h07};
    check_bytes("A");

    // Nine-byte check string.
    for (int i = 0; i < 9; i++) push_byte(8'(8'h31 + i), (i == 8), 1'b0);
    wait_idle();
    chk("B_oe_len", oe_len, 104 * DIV);
    chk("B_done_cnt", done_cnt, 2);
    exp_q = {8'hAA, 8'hAA, 8'h2D, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
             8'h37, 8'h38, 8'h39, 8'hF4};
    check_bytes("B");

    // Starved payload.
    push_byte(8'hA5, 1'b0, 1'b0);
    push_byte(8'h3C, 1'b0, 1'b0);
    wait_idle();
    chk("C_under_cnt", under_cnt, 1);
    chk("C_done_cnt", done_cnt, 2);
    chk("C_oe_len", oe_len, 5 * BYTE_CYC);
    exp_q = {8'hAA, 8'hAA, 8'h2D, 8'hA5, 8'h3C};
    check_bytes("C");

    // Reset during the sync byte.
    push_byte(8'h55, 1'b1, 1'b0);
    repeat (300) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("D_antena", antena, 0);
    chk("D_oe", antena_oe, 0);
    chk("D_busy", busy, 0);
    chk("D_ready", ifc.tx_ready, 1);
    @(posedge clk); #1;
    push_byte(8'h80, 1'b1, 1'b0);
    wait_idle();
    chk("D_done_cnt", done_cnt, 3);
    chk("D_under_cnt", under_cnt, 1);
    exp_q = {8'hAA, 8'hAA, 8'h2D, 8'h80, 8'h89};
    check_bytes("D");

    // tx_valid held high across the frame end.
    push_byte(8'h11, 1'b0, 1'b0);
    push_byte(8'h22, 1'b1, 1'b1);
    ifc.tx_data = 8'h33;
    w = 0;
    while (1) begin
      @(negedge clk);
      if (ifc.tx_ready) break;
      w++;
      if (w > 5000) begin
        nchecks++; nerrors++;
        $display("FAIL E_ready_wait: tx_ready stayed %0d for %0d cycles, required 1", ifc.tx_ready, w);
        break;
      end
    end
    @(posedge clk); #1;
    ifc.tx_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    d1 = done_cyc;
    r2 = rise_cyc;
    chk("E_done_to_restart", r2 - d1, GAP * DIV + 1);
    wait_idle();
    chk("E_done_cnt", done_cnt, 5);
    exp_q = {8'hAA, 8'hAA, 8'h2D, 8'h33, 8'h99};
    check_bytes("E");

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule

// File: doc/wsn_radio_tx.md
WSN_RADIO_TX -- requirements
Module: wsn_radio_tx

Interface
REQ-001 SHALL have parameter DIV, default 16: clock cycles per transmitted bit, legal range 2..255.
REQ-002 SHALL have parameter GAP, default 4: inter-frame silence in bit-times, legal range 1..15.
REQ-003 SHALL have port clk  input  1  system clock; all logic is on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port tx_data  input  8  payload byte from the CPU side.
REQ-006 SHALL have port tx_valid  input  1  tx_data is valid.
REQ-007 SHALL have port tx_last  input  1  the current byte is the final payload byte of the frame.
REQ-008 SHALL have port tx_ready  output  1  the block can accept a byte this cycle.
REQ-009 SHALL have port antena  output  1  serial OOK bit stream to the shared antenna wire.
REQ-010 SHALL have port antena_oe  output  1  drive enable; high only while a frame is on air.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse when a frame completes normally.
REQ-013 SHALL have port underrun  output  1  one-cycle pulse when a frame is aborted.

Function
REQ-014 SHALL implement states IDLE, PRE, SYNC, PAY, CRC, GAP.
REQ-015 A byte is accepted only on a cycle with tx_valid && tx_ready; accepted bytes go into a single 8-bit holding register with a full flag.
REQ-016 tx_ready SHALL be high when the holding register is empty, the state is IDLE, PRE, SYNC or PAY, and tx_last has not yet been accepted in the current frame.
REQ-017 An accept in IDLE SHALL move to PRE on the next edge, with antena_oe=1 and the first preamble bit on antena in that same cycle.
REQ-018 PRE SHALL send two bytes 0xAA, then SYNC SHALL send one byte 0x2D; PAY then follows.
REQ-019 All bytes SHALL be sent MSB first, each bit held for exactly DIV cycles, using a bit-time counter and a 3-bit bit index.
REQ-020 At each PAY byte boundary, the shifter SHALL load from the holding register and clear the full flag, in the same cycle a new accept may set it again.
REQ-021 After the byte flagged tx_last is fully shifted, the state SHALL move to CRC.
REQ-022 CRC SHALL be CRC-8: polynomial 0x07, init 0x00, no reflection, no final XOR, computed over payload bytes only; one 8-bit CRC byte is sent.
REQ-023 At a PAY byte boundary with the holding register empty and tx_last not yet seen, the block SHALL abort: underrun pulses 1 cycle, antena=0, antena_oe=0, and the state goes to GAP.
REQ-024 After CRC, done SHALL pulse 1 cycle at the final bit-time end, and the state goes to GAP with antena_oe=0.
REQ-025 GAP SHALL last GAP*DIV cycles with antena=0, then the state goes to IDLE; tx_ready rises in the first IDLE cycle.
REQ-026 Outside on-air states (PRE, SYNC, PAY, CRC), antena SHALL be 0.
REQ-027 Frame length on air SHALL be (32 + 8*N)*DIV cycles for N payload bytes, measured from the first PRE cycle to the last CRC cycle.
REQ-028 tx_data and tx_last SHALL be ignored when tx_ready is low.

Reset
REQ-029 While reset is high, on each clock edge: state=IDLE, antena=0, antena_oe=0, busy=0, done=0, underrun=0, tx_ready=0, full flag cleared, CRC=0x00, counters cleared.
REQ-030 Reset asserted mid-frame SHALL silence antena and antena_oe on the next edge, discard the frame, and produce no done or underrun pulse.
REQ-031 tx_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-032 Scenario: DIV=16, send byte 0x01 with tx_last=1 -> 640 on-air cycles; bits are AA AA 2D 01 07; done pulses once; antena_oe then drops.
REQ-033 Scenario: send "123456789" (0x31..0x39), last on 0x39 -> the CRC byte on air is 0xF4; 104 bit-times on air.
REQ-034 Scenario: send 2 bytes, with tx_last withheld and tx_valid low at the second byte boundary -> underrun pulses; antena=0 after the 5th byte-time; no CRC and no done.
REQ-035 Scenario: assert reset for 1 cycle during the SYNC byte -> next cycle antena=0, antena_oe=0, busy=0; after release, tx_ready=1 and a new frame transmits correctly.
REQ-036 Scenario: assert tx_valid continuously across frame end -> tx_ready stays 0 through CRC and GAP (GAP*DIV=64 cycles), then the next frame starts in the cycle after the IDLE accept.
